// File: rtl/mac_feed_pkg.sv
// mac_feed_pkg
//   Shared types and constants for the MAC operand feeder.
//   feed_state_t : sequencing states of the feeder FSM.
//   MAC_LATENCY  : cycles from an En sample edge until Cout reflects that
//                  operation (En at edge k, Ain/Bin at k+1, Cout after k+2).
package mac_feed_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    DRAIN,
    DONE
  } feed_state_t;

  localparam int unsigned MAC_LATENCY = 3;

endpackage

// File: rtl/operand_fifo.sv
// operand_fifo
//   Synchronous single-clock FIFO, pointer-plus-count organisation.
//   The read word is registered: dout updates only at the edge where a pop
//   is accepted and then holds until the next pop.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored while full)
//   pop        : read request (ignored while empty)
//   dout       : registered read data
//   full/empty : occupancy flags
module operand_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset: a zero count already makes old words unreachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
//   Upstream stage of the MAC unit. Buffers operand streams A and B in two
//   small FIFOs, sequences the MAC (one Clr, then VEC_LEN En pulses paired
//   with operand pops), waits out the MAC pipeline and captures one dot
//   product, announced by a single-cycle result_valid pulse.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   a_valid/a_ready/a_data     : A operand stream (ready = FIFO not full)
//   b_valid/b_ready/b_data     : B operand stream (ready = FIFO not full)
//   start                      : begin one dot product (honoured in IDLE only)
//   busy                       : high in every state except IDLE
//   mac_en, mac_clr            : MAC control, sampled by the MAC at the edge
//   mac_ain, mac_bin           : registered operands, valid the cycle after En
//   mac_cout                   : MAC accumulator output
//   result_valid, result       : captured dot product and its one-cycle strobe
module mac_operand_feeder
  import mac_feed_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned VEC_LEN    = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [DATA_WIDTH-1:0]   a_data,
  input  logic                    b_valid,
  output logic                    b_ready,
  input  logic [DATA_WIDTH-1:0]   b_data,
  input  logic                    start,
  output logic                    busy,
  output logic                    mac_en,
  output logic                    mac_clr,
  output logic [DATA_WIDTH-1:0]   mac_ain,
  output logic [DATA_WIDTH-1:0]   mac_bin,
  input  logic [3*DATA_WIDTH-1:0] mac_cout,
  output logic                    result_valid,
  output logic [3*DATA_WIDTH-1:0] result
);

  localparam int unsigned DRAIN_W    = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [7:0]  PAIRS      = 8'(VEC_LEN);
  localparam logic [7:0]  LAST_PAIR  = 8'(VEC_LEN - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(MAC_LATENCY - 1);

  feed_state_t        state;
  feed_state_t        next_state;
  logic [7:0]         pair_cnt;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               a_full;
  logic               a_empty;
  logic               b_full;
  logic               b_empty;
  logic               a_push;
  logic               b_push;
  logic               pop;
  logic               capture;

  assign a_ready = !a_full;
  assign b_ready = !b_full;
  assign a_push  = a_valid && a_ready;
  assign b_push  = b_valid && b_ready;

  // Both FIFOs share one pop so A and B words always stay paired.
  operand_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_a_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (a_push),
    .pop   (pop),
    .din   (a_data),
    .dout  (mac_ain),
    .full  (a_full),
    .empty (a_empty)
  );

  operand_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_b_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (b_push),
    .pop   (pop),
    .din   (b_data),
    .dout  (mac_bin),
    .full  (b_full),
    .empty (b_empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = CLR;
      CLR:     next_state = RUN;
      RUN:     if (pop && (pair_cnt == LAST_PAIR)) next_state = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRAIN) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output logic. En is asserted in the same cycle as the pop: the MAC
  // samples En at the pop edge and the popped words appear on Ain/Bin in
  // the following cycle, exactly when the MAC captures them.
  always_comb begin
    pop     = 1'b0;
    mac_clr = 1'b0;
    busy    = 1'b1;
    unique case (state)
      IDLE:    busy = 1'b0;
      CLR:     mac_clr = 1'b1;
      RUN:     pop = !a_empty && !b_empty && (pair_cnt < PAIRS);
      default: ;
    endcase
  end

  assign mac_en = pop;

  // Last En is sampled at edge k; DRAIN spans the cycles after k, k+1 and
  // k+2, so the capture edge (k+3) sees Cout already reflecting that En.
  // Capturing on entry to DONE lets result and result_valid appear together
  // during the DONE cycle.
  assign capture = (state == DRAIN) && (drain_cnt == LAST_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_cnt     <= '0;
      drain_cnt    <= '0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      if (state == CLR) begin
        pair_cnt <= '0;
      end else if (pop) begin
        pair_cnt <= pair_cnt + 8'd1;
      end

      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + DRAIN_W'(1);
      end else begin
        drain_cnt <= '0;
      end

      result_valid <= capture;
      if (capture) begin
        result <= mac_cout;
      end
    end
  end

endmodule
